rf_bypass_mp: RTL and testbench

- Parametrised multi-port register file with built-in write-to-read bypass.
- Generalises the 8x16b two-read/one-write bypassed RF to configurable width, depth, read-port count and write-port count.
- Adds optional registered read (pipelined decode stage), hardwired-zero register mode, and registered error reporting.
- Sits in the decode stage; it is the single source of architectural register state for the pipeline.

---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_bypass_sel.sv | 37 +++
 rtl/rf_bypass_mp.sv | 116 +++++++++++
 tb/tb_rf_bypass_mp.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the bypassed multi-port register file.
package rf_pkg;

  localparam int RF_WIDTH = 16;
  localparam int RF_DEPTH = 8;
  localparam int RF_AW    = 3;

  localparam int READ_LAT_COMB = 0;
  localparam int READ_LAT_REG  = 1;

  // Smallest index width that can address every register (at least 1 bit).
  function automatic int rf_calc_aw(input int depth);
    int aw;
    aw = 1;
    while ((1 << aw) < depth) aw++;
    return aw;
  endfunction

endpackage

// File: rtl/rf_bypass_sel.sv
// Per-read-port bypass mux: forwards the winning same-cycle write, else the stored value.
module rf_bypass_sel
  import rf_pkg::*;
#(
  parameter int WIDTH   = RF_WIDTH,
  parameter int DEPTH   = RF_DEPTH,
  parameter int AW      = RF_AW,
  parameter int NWR     = 2,
  parameter int ZERO_R0 = 0
) (
  input  logic [AW-1:0]        rd_sel_i,
  input  logic [WIDTH-1:0]     stored_i,
  input  logic [NWR-1:0]       wr_en_i,
  input  logic [NWR*AW-1:0]    wr_sel_i,
  input  logic [NWR*WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0]     rd_data_o
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [AW-1:0] wsel;

  // Ascending scan: a later (higher-numbered) matching port overrides earlier ones.
  always_comb begin
    rd_data_o = stored_i;
    wsel      = '0;
    for (int w = 0; w < NWR; w++) begin
      wsel = wr_sel_i[w*AW +: AW];
      if (wr_en_i[w] && ({1'b0, wsel} < DEPTH_W) &&
          !((ZERO_R0 != 0) && (wsel == '0)) && (wsel == rd_sel_i))
        rd_data_o = wr_data_i[w*WIDTH +: WIDTH];
    end
    if (({1'b0, rd_sel_i} >= DEPTH_W) || ((ZERO_R0 != 0) && (rd_sel_i == '0)))
      rd_data_o = '0;
  end

endmodule

// File: rtl/rf_bypass_mp.sv
// Parametrised multi-port register file with write-to-read bypass, optional
// registered read, hardwired-zero r0 and a one-cycle error pulse.
module rf_bypass_mp
  import rf_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int AW       = RF_AW,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int READ_LAT = READ_LAT_COMB,
  parameter int ZERO_R0  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_sel,
  output logic [NRD*WIDTH-1:0] rd_data,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_sel,
  input  logic [NWR*WIDTH-1:0] wr_data,
  output logic                 err
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  if (AW < rf_calc_aw(DEPTH)) begin : g_bad_aw
    $error("rf_bypass_mp: AW too small for DEPTH");
  end

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [WIDTH-1:0]     mem_d [DEPTH];
  logic [NWR-1:0]       wr_ok;
  logic [NRD*WIDTH-1:0] byp;
  logic                 err_d, err_q;

  always_comb begin
    for (int w = 0; w < NWR; w++) begin
      wr_ok[w] = wr_en[w] && ({1'b0, wr_sel[w*AW +: AW]} < DEPTH_W) &&
                 !((ZERO_R0 != 0) && (wr_sel[w*AW +: AW] == '0));
    end
  end

  // Later ports are applied last, so the highest-numbered port wins a collision.
  always_comb begin
    mem_d = mem_q;
    for (int w = 0; w < NWR; w++) begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wr_ok[w] && (wr_sel[w*AW +: AW] == AW'(r)))
          mem_d[r] = wr_data[w*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_q <= '{default: '0};
    else      mem_q <= mem_d;
  end

  always_comb begin
    err_d = 1'b0;
    for (int a = 0; a < NWR; a++) begin
      if (wr_en[a] && ({1'b0, wr_sel[a*AW +: AW]} >= DEPTH_W)) err_d = 1'b1;
      for (int b = a + 1; b < NWR; b++) begin
        if (wr_en[a] && wr_en[b] && (wr_sel[a*AW +: AW] == wr_sel[b*AW +: AW]) &&
            ({1'b0, wr_sel[a*AW +: AW]} < DEPTH_W))
          err_d = 1'b1;
      end
    end
    for (int i = 0; i < NRD; i++) begin
      if ({1'b0, rd_sel[i*AW +: AW]} >= DEPTH_W) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]    sel;
    logic [WIDTH-1:0] stored;

    assign sel    = rd_sel[i*AW +: AW];
    assign stored = ({1'b0, sel} < DEPTH_W) ? mem_q[sel] : '0;

    rf_bypass_sel #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .AW      (AW),
      .NWR     (NWR),
      .ZERO_R0 (ZERO_R0)
    ) u_sel (
      .rd_sel_i  (sel),
      .stored_i  (stored),
      .wr_en_i   (wr_en),
      .wr_sel_i  (wr_sel),
      .wr_data_i (wr_data),
      .rd_data_o (byp[i*WIDTH +: WIDTH])
    );
  end

  // Registering the bypassed value gives post-write contents one cycle later.
  if (READ_LAT == READ_LAT_REG) begin : g_lat1
    logic [NRD*WIDTH-1:0] rd_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd_q <= '0;
      else      rd_q <= byp;
    end
    assign rd_data = rd_q;
  end else begin : g_lat0
    assign rd_data = byp;
  end

endmodule

// File: tb/tb_rf_bypass_mp.sv
// Scoreboard bench: three configurations share one stimulus stream.
module tb_rf_bypass_mp;

  localparam int W   = 16;
  localparam int AW  = 3;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NRD*AW-1:0] rd_sel;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_sel;
  logic [NWR*W-1:0]  wr_data;
  logic [NRD*W-1:0]  rd_a, rd_b, rd_c;
  logic              err_a, err_b, err_c;

  always #5 clk = ~clk;

  rf_bypass_mp #(.WIDTH(W), .DEPTH(8), .AW(AW), .NRD(NRD), .NWR(NWR),
                 .READ_LAT(0), .ZERO_R0(0)) dut_a (
    .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_data(rd_a),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .err(err_a));

  rf_bypass_mp #(.WIDTH(W), .DEPTH(8), .AW(AW), .NRD(NRD), .NWR(NWR),
                 .READ_LAT(1), .ZERO_R0(0)) dut_b (
    .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_data(rd_b),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .err(err_b));

  rf_bypass_mp #(.WIDTH(W), .DEPTH(6), .AW(AW), .NRD(NRD), .NWR(NWR),
                 .READ_LAT(0), .ZERO_R0(1)) dut_c (
    .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_data(rd_c),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .err(err_c));

  typedef struct packed {
    logic [NRD*W-1:0] rd_a;
    logic [NRD*W-1:0] rd_c;
  } comb_t;

  typedef struct packed {
    logic [NRD*W-1:0] rd_b;
    logic             err_a;
    logic             err_b;
    logic             err_c;
  } reg_t;

  comb_t comb_q[$];
  reg_t  reg_q[$];

  logic [W-1:0] m8 [8];
  logic [W-1:0] m6 [6];
  logic [W-1:0] nx8 [8];
  logic [W-1:0] nx6 [6];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Contents after this edge's writes: apply writes in port order.
  task automatic model_next();
    int s;
    for (int r = 0; r < 8; r++) nx8[r] = m8[r];
    for (int r = 0; r < 6; r++) nx6[r] = m6[r];
    for (int w = 0; w < NWR; w++) begin
      s = int'(wr_sel[w*AW +: AW]);
      if (wr_en[w]) begin
        if (s < 8) nx8[s] = wr_data[w*W +: W];
        if (s < 6 && s != 0) nx6[s] = wr_data[w*W +: W];
      end
    end
  endtask

  function automatic logic exp_err(input int depth);
    logic e;
    e = 1'b0;
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && int'(wr_sel[w*AW +: AW]) >= depth) e = 1'b1;
    for (int i = 0; i < NRD; i++)
      if (int'(rd_sel[i*AW +: AW]) >= depth) e = 1'b1;
    if (wr_en == 2'b11 && wr_sel[0 +: AW] == wr_sel[AW +: AW] && int'(wr_sel[0 +: AW]) < depth)
      e = 1'b1;
    return e;
  endfunction

  function automatic reg_t zero_reg();
    reg_t z;
    z = '0;
    return z;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 8; r++) m8[r] = '0;
    for (int r = 0; r < 6; r++) m6[r] = '0;
  endtask

  // Called just after a rising edge; drives one cycle and checks at the falling edge.
  task automatic step(input logic [NRD*AW-1:0] rs, input logic [NWR-1:0] we,
                      input logic [NWR*AW-1:0] ws, input logic [NWR*W-1:0] wd);
    comb_t ce, ca;
    reg_t  re, ra;
    int    s;
    rd_sel = rs; wr_en = we; wr_sel = ws; wr_data = wd;
    model_next();
    ce = '0;
    for (int i = 0; i < NRD; i++) begin
      s = int'(rs[i*AW +: AW]);
      ce.rd_a[i*W +: W] = (s < 8) ? nx8[s] : '0;
      ce.rd_c[i*W +: W] = (s < 6 && s != 0) ? nx6[s] : '0;
    end
    re.rd_b  = ce.rd_a;
    re.err_a = exp_err(8);
    re.err_b = exp_err(8);
    re.err_c = exp_err(6);
    comb_q.push_back(ce);
    @(negedge clk);
    ca = comb_q.pop_front();
    check("rd_lat0", rd_a, ca.rd_a);
    check("rd_zero_d6", rd_c, ca.rd_c);
    ra = reg_q.pop_front();
    check("rd_lat1", rd_b, ra.rd_b);
    check("err_a", {31'd0, err_a}, {31'd0, ra.err_a});
    check("err_b", {31'd0, err_b}, {31'd0, ra.err_b});
    check("err_c", {31'd0, err_c}, {31'd0, ra.err_c});
    reg_q.push_back(re);
    @(posedge clk);
    for (int r = 0; r < 8; r++) m8[r] = nx8[r];
    for (int r = 0; r < 6; r++) m6[r] = nx6[r];
    #1;
  endtask

  initial begin
    rst = 1'b0; rd_sel = '0; wr_en = '0; wr_sel = '0; wr_data = '0;
    model_clear();
    @(posedge clk); #1;
    check("reset_rd_a", rd_a, 32'h0);
    check("reset_rd_b", rd_b, 32'h0);
    check("reset_err", {31'd0, err_a}, 32'h0);
    rst = 1'b1;
    reg_q.push_back(zero_reg());

    step({3'd0, 3'd0}, 2'b01, {3'd0, 3'd3}, {16'h0, 16'hBEEF});
    step({3'd3, 3'd3}, 2'b00, 6'd0, 32'h0);

    // Asynchronous reset mid-cycle, held across an edge carrying a write.
    rd_sel = {3'd3, 3'd3}; wr_en = '0;
    #2 rst = 1'b0;
    #1;
    check("async_rst_rd_a", rd_a, 32'h0);
    check("async_rst_rd_b", rd_b, 32'h0);
    check("async_rst_rd_c", rd_c, 32'h0);
    check("async_rst_err", {31'd0, err_a}, 32'h0);
    wr_en = 2'b01; wr_sel = {3'd0, 3'd3}; wr_data = {16'h0, 16'hBEEF};
    @(posedge clk); #1;
    rst = 1'b1;
    model_clear();
    comb_q.delete();
    reg_q.delete();
    reg_q.push_back(zero_reg());
    step({3'd3, 3'd3}, 2'b00, 6'd0, 32'h0);

    // Bypass on port 0, then the stored value.
    step({3'd0, 3'd5}, 2'b01, {3'd0, 3'd5}, {16'h0, 16'h1234});
    step({3'd5, 3'd5}, 2'b00, 6'd0, 32'h0);

    // Collision: port 1 wins, err pulses once.
    step({3'd2, 3'd0}, 2'b11, {3'd2, 3'd2}, {16'h2222, 16'h1111});
    step({3'd2, 3'd2}, 2'b00, 6'd0, 32'h0);
    step({3'd2, 3'd2}, 2'b00, 6'd0, 32'h0);

    // Registered read sees same-edge write, not the following one.
    step({3'd0, 3'd4}, 2'b01, {3'd0, 3'd4}, {16'h0, 16'hA5A5});
    step({3'd0, 3'd1}, 2'b01, {3'd0, 3'd4}, {16'h0, 16'h0F0F});
    step({3'd4, 3'd4}, 2'b00, 6'd0, 32'h0);

    // Hardwired-zero r0.
    step({3'd0, 3'd0}, 2'b01, {3'd0, 3'd0}, {16'h0, 16'hFFFF});
    step({3'd0, 3'd0}, 2'b00, 6'd0, 32'h0);

    // Out-of-range write and read on the depth-6 instance.
    step({3'd0, 3'd6}, 2'b01, {3'd0, 3'd7}, {16'h0, 16'hDEAD});
    step({3'd1, 3'd1}, 2'b00, 6'd0, 32'h0);
    step({3'd1, 3'd1}, 2'b00, 6'd0, 32'h0);

    for (int n = 0; n < 300; n++)
      step(6'($urandom), 2'($urandom), 6'($urandom), $urandom);

    step(6'd0, 2'b00, 6'd0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
